// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl
//   Drives an external bank of WIDTH T flip-flops so that it behaves as a
//   modulo-N up/down counter. Each RUN cycle it reads the bank state q and
//   produces toggle enables t that move the bank one step at the same edge.
//   A run lasts a programmed number of wrap-arounds, then done pulses.
//
// Optional feature macro: TFFCTRL_PAUSE_EN (adds the pause input).
//
// Ports:
//   CLK       clock, all state changes on posedge
//   RST       asynchronous active-low reset
//   start     begin a run (sampled in IDLE only)
//   stop      abort the current run, takes priority over start and pause
//   up        count direction, 1 = up (latched at start)
//   modulus   count modulus N, 0 means 2^WIDTH (latched at start)
//   wraps     wrap target, 0 means run until stop (latched at start)
//   pause     (TFFCTRL_PAUSE_EN only) hold the bank and wrap count in RUN
//   q         current bank state
//   t         per-bit toggle enables to the bank
//   clr_n     active-low synchronous clear to the bank
//   busy      high in CLEAR and RUN
//   wrap      high in any RUN cycle where t wraps the count
//   done      one-cycle completion pulse
//   wrap_cnt  wraps completed in the current run (saturating)
// ---------------------------------------------------------------------------
module tff_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic [WIDTH-1:0] modulus,
  input  logic [CW-1:0]    wraps,
`ifdef TFFCTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             clr_n,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [CW-1:0]    wrap_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state;
  logic             upLat;
  logic [WIDTH-1:0] modLat;
  logic [CW-1:0]    wrapsLat;

  logic [WIDTH-1:0] maxVal;
  logic [WIDTH-1:0] incT;
  logic [WIDTH-1:0] decT;
  logic [WIDTH-1:0] stepT;
  logic             stepWrap;
  logic             carry;
  logic             borrow;
  logic             advance;
  logic             holdRun;
  logic [CW-1:0]    cntNext;
  logic             hitTarget;

  // Largest count value; modulus 0 underflows to all-ones, i.e. 2^WIDTH.
  assign maxVal = modLat - WIDTH'(1);

  // Toggle pattern for one step from the current bank state.
  // A bit toggles on increment when all lower bits are 1, and on
  // decrement when all lower bits are 0.
  always_comb begin
    incT     = '0;
    decT     = '0;
    stepT    = '0;
    stepWrap = 1'b0;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      incT[i] = carry;
      decT[i] = borrow;
      carry   = carry & q[i];
      borrow  = borrow & ~q[i];
    end
    if (upLat) begin
      if (q >= maxVal) begin
        stepT    = q;
        stepWrap = 1'b1;
      end else begin
        stepT = incT;
      end
    end else if (q == '0) begin
      stepT    = maxVal;
      stepWrap = 1'b1;
    end else if (q <= maxVal) begin
      stepT = decT;
    end else begin
      // Out-of-range state: jump straight to maxVal without counting a wrap.
      stepT = q ^ maxVal;
    end
  end

`ifdef TFFCTRL_PAUSE_EN
  assign holdRun = pause;
`else
  assign holdRun = 1'b0;
`endif

  // The bank only moves in RUN cycles that are neither aborted nor paused.
  assign advance   = (state == RUN) && !stop && !holdRun;
  assign t         = advance ? stepT : '0;
  assign wrap      = advance && stepWrap;

  assign cntNext   = wrap_cnt + CW'(1);
  assign hitTarget = (wrapsLat != '0) && (cntNext == wrapsLat);

  // Remaining outputs decode straight from the state register.
  assign clr_n = (state != CLEAR);
  assign busy  = (state == CLEAR) || (state == RUN);
  assign done  = (state == DONE);

  // Sequencer: latches config on start, counts wraps and ends the run
  // either on the wrap target (through DONE) or on stop (straight to IDLE).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      upLat    <= 1'b0;
      modLat   <= '0;
      wrapsLat <= '0;
      wrap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            upLat    <= up;
            modLat   <= modulus;
            wrapsLat <= wraps;
            wrap_cnt <= '0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          state <= stop ? IDLE : RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (advance && stepWrap) begin
            if (wrap_cnt != '1) begin
              wrap_cnt <= cntNext;
            end
            if (hitTarget) begin
              state <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tff_count_ctrl
//   Scoreboard bench for tff_count_ctrl. The bench owns a behavioural T
//   flip-flop bank. Stimulus pushes hand-computed expected cycles into a
//   queue; the monitor pops one entry for every cycle the DUT shows busy or
//   done and compares all outputs plus the bank state.
//   Build with TFFCTRL_PAUSE_EN defined to include the pause scenario.
// ---------------------------------------------------------------------------
module tb_tff_count_ctrl;

  typedef struct packed {
    logic [3:0] t;
    logic       clrN;
    logic       busy;
    logic       wrap;
    logic       done;
    logic [7:0] cnt;
    logic [3:0] q;
    logic       chkQ;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       up = 1'b0;
  logic [3:0] modulus = '0;
  logic [7:0] wraps = '0;
`ifdef TFFCTRL_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [3:0] q = 4'b1010;
  logic [3:0] t;
  logic       clr_n;
  logic       busy;
  logic       wrap;
  logic       done;
  logic [7:0] wrap_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  tff_count_ctrl #(.WIDTH(4), .CW(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .stop(stop),
    .up(up),
    .modulus(modulus),
    .wraps(wraps),
`ifdef TFFCTRL_PAUSE_EN
    .pause(pause),
`endif
    .q(q),
    .t(t),
    .clr_n(clr_n),
    .busy(busy),
    .wrap(wrap),
    .done(done),
    .wrap_cnt(wrap_cnt)
  );

  always #5 CLK = ~CLK;

  // External toggle bank: synchronous clear, otherwise toggle per t.
  always @(posedge CLK) begin
    if (!clr_n) q <= '0;
    else        q <= q ^ t;
  end

  // Monitor: one expected entry per busy/done cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (RST && (busy || done)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpectedOutput: got t=%b busy=%b done=%b q=%0d, required no activity",
                 t, busy, done, q);
      end else begin
        e = sb.pop_front();
        if (t !== e.t || clr_n !== e.clrN || busy !== e.busy || wrap !== e.wrap ||
            done !== e.done || wrap_cnt !== e.cnt || (e.chkQ && q !== e.q)) begin
          failures++;
          $display("[TB] FAIL cycle @%0t: got t=%b clr_n=%b busy=%b wrap=%b done=%b cnt=%0d q=%0d, required t=%b clr_n=%b busy=%b wrap=%b done=%b cnt=%0d q=%0d(chk=%0b)",
                   $time, t, clr_n, busy, wrap, done, wrap_cnt, q,
                   e.t, e.clrN, e.busy, e.wrap, e.done, e.cnt, e.q, e.chkQ);
        end
      end
    end
  end

  task automatic pushClear();
    sb.push_back('{t: 4'b0000, clrN: 1'b0, busy: 1'b1, wrap: 1'b0, done: 1'b0,
                   cnt: 8'd0, q: 4'd0, chkQ: 1'b0});
  endtask

  task automatic pushRun(input logic [3:0] et, input logic ew, input logic [7:0] ec,
                         input logic [3:0] eq);
    sb.push_back('{t: et, clrN: 1'b1, busy: 1'b1, wrap: ew, done: 1'b0,
                   cnt: ec, q: eq, chkQ: 1'b1});
  endtask

  task automatic pushDone(input logic [7:0] ec, input logic [3:0] eq);
    sb.push_back('{t: 4'b0000, clrN: 1'b1, busy: 1'b0, wrap: 1'b0, done: 1'b1,
                   cnt: ec, q: eq, chkQ: 1'b1});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Pulse start for one edge with the given config; returns inside CLEAR.
  task automatic applyStimulus(input logic u, input logic [3:0] m, input logic [7:0] w);
    @(posedge CLK);
    #1;
    up = u; modulus = m; wraps = w; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for the controller to return to idle, then require an empty scoreboard.
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy || done) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    #1;
    if (n >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: got busy=%b, required idle within 200 cycles", name, busy);
    end
    checkOutput({name, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    checkOutput("reset_t", t, 0);
    checkOutput("reset_clr_n", clr_n, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wrap", wrap, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wrap_cnt", wrap_cnt, 0);
    RST = 1'b1;

    // Up, modulus 5, two wraps.
    pushClear();
    pushRun(4'b0001, 0, 0, 0); pushRun(4'b0011, 0, 0, 1); pushRun(4'b0001, 0, 0, 2);
    pushRun(4'b0111, 0, 0, 3); pushRun(4'b0100, 1, 0, 4);
    pushRun(4'b0001, 0, 1, 0); pushRun(4'b0011, 0, 1, 1); pushRun(4'b0001, 0, 1, 2);
    pushRun(4'b0111, 0, 1, 3); pushRun(4'b0100, 1, 1, 4);
    pushDone(2, 0);
    applyStimulus(1'b1, 4'd5, 8'd2);
    waitIdle("up_mod5");

    // Down, modulus 3, two wraps.
    pushClear();
    pushRun(4'b0010, 1, 0, 0); pushRun(4'b0011, 0, 1, 2); pushRun(4'b0001, 0, 1, 1);
    pushRun(4'b0010, 1, 1, 0);
    pushDone(2, 2);
    applyStimulus(1'b0, 4'd3, 8'd2);
    waitIdle("down_mod3");

    // Up, full range (modulus 0), one wrap.
    pushClear();
    for (int v = 0; v < 16; v++) pushRun(4'(v ^ (v + 1)), v == 15, 0, 4'(v));
    pushDone(1, 0);
    applyStimulus(1'b1, 4'd0, 8'd1);
    waitIdle("up_full");

    // Up, modulus 10, free-running, stopped at q=6.
    pushClear();
    for (int v = 0; v < 6; v++) pushRun(4'(v ^ (v + 1)), 0, 0, 4'(v));
    pushRun(4'b0000, 0, 0, 6);
    applyStimulus(1'b1, 4'd10, 8'd0);
    repeat (7) @(posedge CLK);
    #1 stop = 1'b1;
    @(posedge CLK);
    #1 stop = 1'b0;
    checkOutput("stop_busy_drop", busy, 0);
    checkOutput("stop_wrap_cnt", wrap_cnt, 0);
    waitIdle("stop_q6");
    checkOutput("stop_bank_hold", q, 6);

    // Reset mid-run on the second q=3 (modulus 4, wrap_cnt already 1).
    pushClear();
    pushRun(4'b0001, 0, 0, 0); pushRun(4'b0011, 0, 0, 1); pushRun(4'b0001, 0, 0, 2);
    pushRun(4'b0011, 1, 0, 3);
    pushRun(4'b0001, 0, 1, 0); pushRun(4'b0011, 0, 1, 1); pushRun(4'b0001, 0, 1, 2);
    applyStimulus(1'b1, 4'd4, 8'd0);
    repeat (8) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_wrap_cnt", wrap_cnt, 0);
    checkOutput("midreset_t", t, 0);
    waitIdle("midreset");
    @(negedge CLK);
    RST = 1'b1;

    // start together with stop in IDLE: stop wins.
    @(posedge CLK);
    #1 start = 1'b1; stop = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0; stop = 1'b0;
    checkOutput("startstop_busy", busy, 0);
    @(posedge CLK);
    #1;
    checkOutput("startstop_clr_n", clr_n, 1);
    checkOutput("startstop_busy2", busy, 0);

    // start (and new config) during RUN is ignored.
    pushClear();
    pushRun(4'b0001, 0, 0, 0); pushRun(4'b0011, 0, 0, 1); pushRun(4'b0001, 0, 0, 2);
    pushRun(4'b0111, 0, 0, 3); pushRun(4'b0100, 1, 0, 4);
    pushDone(1, 0);
    applyStimulus(1'b1, 4'd5, 8'd1);
    repeat (2) @(posedge CLK);
    #1 start = 1'b1; up = 1'b0; modulus = 4'd3; wraps = 8'd5;
    @(posedge CLK);
    #1 start = 1'b0;
    waitIdle("start_in_run");

`ifdef TFFCTRL_PAUSE_EN
    // Pause three cycles at q=2, resume, then stop at q=4.
    pushClear();
    pushRun(4'b0001, 0, 0, 0); pushRun(4'b0011, 0, 0, 1);
    pushRun(4'b0000, 0, 0, 2); pushRun(4'b0000, 0, 0, 2); pushRun(4'b0000, 0, 0, 2);
    pushRun(4'b0001, 0, 0, 2); pushRun(4'b0111, 0, 0, 3);
    pushRun(4'b0000, 0, 0, 4);
    applyStimulus(1'b1, 4'd10, 8'd0);
    repeat (3) @(posedge CLK);
    #1 pause = 1'b1;
    repeat (3) @(posedge CLK);
    #1 pause = 1'b0;
    repeat (2) @(posedge CLK);
    #1 stop = 1'b1;
    @(posedge CLK);
    #1 stop = 1'b0;
    waitIdle("pause");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
